hazard_forward_ctrl: RTL and testbench



---
 rtl/hazard_forward_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding and hazard control for the 5-stage RISC-V pipeline.
// In: ID/EX/MEM/WB register indices and write/load flags, mem_load_valid, flush.
// Out: forward_a/b (00 rf, 01 WB, 10 MEM), stall_front, stall_ex, bubble_ex,
//      bubble_wb, stall_cycles (saturating), mem_timeout (sticky).
module hazard_forward_ctrl #(
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_reg_write,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_load_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              flush,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall_front,
    output logic              stall_ex,
    output logic              bubble_ex,
    output logic              bubble_wb,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              mem_timeout
);

    localparam int WCW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] LIMIT = WCW'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic       mem_wr_ok, wb_wr_ok;
    logic       lu_hazard, mem_busy;
    logic [1:0] fa, fb;
    logic       sf, se, bex, bwb;

    assign mem_wr_ok = mem_reg_write && (mem_rd != '0);
    assign wb_wr_ok  = wb_reg_write && (wb_rd != '0);

    // Newest producer (MEM) wins over WB.
    always_comb begin
        fa = 2'b00;
        fb = 2'b00;
        if (mem_wr_ok && mem_rd == ex_rs1) begin
            fa = 2'b10;
        end else if (wb_wr_ok && wb_rd == ex_rs1) begin
            fa = 2'b01;
        end
        if (mem_wr_ok && mem_rd == ex_rs2) begin
            fb = 2'b10;
        end else if (wb_wr_ok && wb_rd == ex_rs2) begin
            fb = 2'b01;
        end
    end

    assign lu_hazard = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                       ((id_uses_rs1 && id_rs1 == ex_rd) ||
                        (id_uses_rs2 && id_rs2 == ex_rd));
    assign mem_busy  = mem_is_load && !mem_load_valid;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        sf            = 1'b0;
        se            = 1'b0;
        bex           = 1'b0;
        bwb           = 1'b0;
        case (state_q)
            MEM_WAIT: begin
                // Flush is ignored here: the load in MEM must complete.
                if (mem_busy) begin
                    sf  = 1'b1;
                    se  = 1'b1;
                    bwb = 1'b1;
                    if (wait_cnt_q != LIMIT) begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                    if (wait_cnt_d == LIMIT) begin
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN, LU_STALL: begin
                // LU_STALL is RUN with the load now in MEM; a new hazard
                // (back-to-back loads) is handled identically.
                if (mem_busy) begin
                    sf         = 1'b1;
                    se         = 1'b1;
                    bwb        = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = MEM_WAIT;
                end else if (lu_hazard && !flush) begin
                    sf      = 1'b1;
                    bex     = 1'b1;
                    state_d = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (sf && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign forward_a    = rst_n ? fa : 2'b00;
    assign forward_b    = rst_n ? fb : 2'b00;
    assign stall_front  = rst_n & sf;
    assign stall_ex     = rst_n & se;
    assign bubble_ex    = rst_n & bex;
    assign bubble_wb    = rst_n & bwb;
    assign stall_cycles = stall_cycles_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: vector table plus
// hand-written multi-cycle sequences (load-use, mem wait, timeout, reset).
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_is_load;
    logic        mem_reg_write, mem_is_load, mem_load_valid, wb_reg_write;
    logic        flush;
    logic [1:0]  forward_a, forward_b;
    logic        stall_front, stall_ex, bubble_ex, bubble_wb;
    logic [31:0] stall_cycles;
    logic        mem_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(
        .REG_AW(5), .CNT_W(32), .WAIT_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .mem_rd(mem_rd), .mem_load_valid(mem_load_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .flush(flush),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_front(stall_front), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
        .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    // ctl = {stall_front, stall_ex, bubble_ex, bubble_wb}
    typedef struct {
        string      name;
        logic [4:0] id_rs1, id_rs2;
        logic       u1, u2;
        logic [4:0] ex_rs1, ex_rs2;
        logic       ex_rw, ex_ld;
        logic [4:0] ex_rd;
        logic       mem_rw;
        logic [4:0] mem_rd;
        logic       wb_rw;
        logic [4:0] wb_rd;
        logic       fl;
        logic [1:0] fa, fb;
        logic [3:0] ctl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        string n, logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
        logic [4:0] e1, logic [4:0] e2, logic erw, logic eld, logic [4:0] erd,
        logic mrw, logic [4:0] mrd, logic wrw, logic [4:0] wrd, logic fl,
        logic [1:0] fa, logic [1:0] fb, logic [3:0] ctl);
        vec_t v;
        v.name = n; v.id_rs1 = r1; v.id_rs2 = r2; v.u1 = u1; v.u2 = u2;
        v.ex_rs1 = e1; v.ex_rs2 = e2; v.ex_rw = erw; v.ex_ld = eld;
        v.ex_rd = erd; v.mem_rw = mrw; v.mem_rd = mrd; v.wb_rw = wrw;
        v.wb_rd = wrd; v.fl = fl; v.fa = fa; v.fb = fb; v.ctl = ctl;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [3:0] ctl();
        return {stall_front, stall_ex, bubble_ex, bubble_wb};
    endfunction

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd = 0;
        mem_reg_write = 0; mem_is_load = 0; mem_rd = 0; mem_load_valid = 0;
        wb_reg_write = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        // Nonzero forwarding inputs during reset: outputs must still be 0.
        mem_reg_write = 1; mem_rd = 5; ex_rs1 = 5;
        #3;
        chk("reset_fwd_a", 32'(forward_a), 32'd0);
        chk("reset_stall_cycles", stall_cycles, 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);
        do_reset();

        vecs.push_back(mk("fwd_mem_pri", 0,0,0,0, 5,3,0,0,0, 1,5, 1,5, 0,
                          2'b10, 2'b00, 4'b0000));
        vecs.push_back(mk("fwd_wb", 0,0,0,0, 5,3,0,0,0, 0,5, 1,5, 0,
                          2'b01, 2'b00, 4'b0000));
        vecs.push_back(mk("fwd_x0", 0,0,0,0, 0,0,0,0,0, 1,0, 1,0, 0,
                          2'b00, 2'b00, 4'b0000));
        vecs.push_back(mk("fwd_both_mem", 0,0,0,0, 9,9,0,0,0, 1,9, 1,9, 0,
                          2'b10, 2'b10, 4'b0000));
        vecs.push_back(mk("fwd_split", 0,0,0,0, 6,4,0,0,0, 1,4, 1,6, 0,
                          2'b01, 2'b10, 4'b0000));
        vecs.push_back(mk("fwd_wb_nowr", 0,0,0,0, 3,3,0,0,0, 0,3, 0,3, 0,
                          2'b00, 2'b00, 4'b0000));
        vecs.push_back(mk("lu_rs1", 7,0,1,0, 0,0,1,1,7, 0,0, 0,0, 0,
                          2'b00, 2'b00, 4'b1010));
        vecs.push_back(mk("lu_nouse", 0,7,0,0, 0,0,1,1,7, 0,0, 0,0, 0,
                          2'b00, 2'b00, 4'b0000));
        vecs.push_back(mk("lu_flush", 0,7,0,1, 0,0,1,1,7, 0,0, 0,0, 1,
                          2'b00, 2'b00, 4'b0000));
        vecs.push_back(mk("lu_rs2", 0,7,0,1, 0,0,1,1,7, 0,0, 0,0, 0,
                          2'b00, 2'b00, 4'b1010));
        vecs.push_back(mk("lu_rd0", 0,0,1,1, 0,0,1,1,0, 0,0, 0,0, 0,
                          2'b00, 2'b00, 4'b0000));
        vecs.push_back(mk("lu_noload", 7,0,1,0, 0,0,1,0,7, 0,0, 0,0, 0,
                          2'b00, 2'b00, 4'b0000));

        foreach (vecs[i]) begin
            @(negedge clk);
            clear_inputs();
            id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2;
            ex_reg_write = vecs[i].ex_rw; ex_is_load = vecs[i].ex_ld;
            ex_rd = vecs[i].ex_rd; mem_reg_write = vecs[i].mem_rw;
            mem_rd = vecs[i].mem_rd; wb_reg_write = vecs[i].wb_rw;
            wb_rd = vecs[i].wb_rd; flush = vecs[i].fl;
            #1;
            chk({vecs[i].name, "_fa"}, 32'(forward_a), 32'(vecs[i].fa));
            chk({vecs[i].name, "_fb"}, 32'(forward_b), 32'(vecs[i].fb));
            chk({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].ctl));
        end

        // Load-use: stall one cycle, then load forwards from MEM.
        do_reset();
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 7;
        id_rs2 = 7; id_uses_rs2 = 1;
        #1;
        chk("lu_c0_ctl", 32'(ctl()), 32'b1010);
        @(negedge clk);
        clear_inputs();
        mem_is_load = 1; mem_reg_write = 1; mem_rd = 7; mem_load_valid = 1;
        ex_rs2 = 7;
        #1;
        chk("lu_c1_ctl", 32'(ctl()), 32'b0000);
        chk("lu_c1_fb", 32'(forward_b), 32'b10);
        chk("lu_c1_cnt", stall_cycles, 32'd1);

        // Memory wait 3 cycles with a simultaneous load-use hazard.
        do_reset();
        mem_is_load = 1; mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3;
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 8;
        id_rs1 = 8; id_uses_rs1 = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("wait3_c%0d_ctl", k), 32'(ctl()), 32'b1101);
            chk($sformatf("wait3_c%0d_fa", k), 32'(forward_a), 32'b10);
            @(negedge clk);
        end
        mem_load_valid = 1;
        #1;
        chk("wait3_done_ctl", 32'(ctl()), 32'b0000);
        chk("wait3_cnt", stall_cycles, 32'd3);
        chk("wait3_timeout", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        mem_is_load = 0; mem_load_valid = 0;
        #1;
        chk("wait3_lu_reeval", 32'(ctl()), 32'b1010);

        // Timeout (WAIT_LIMIT=4): flush during wait must not matter.
        do_reset();
        mem_is_load = 1;
        for (int k = 0; k < 10; k++) begin
            flush = (k == 6);
            #1;
            chk($sformatf("to_c%0d_ctl", k), 32'(ctl()), 32'b1101);
            chk($sformatf("to_c%0d_flag", k), 32'(mem_timeout),
                32'(k >= 5));
            @(negedge clk);
        end
        flush = 0;
        mem_load_valid = 1;
        #1;
        chk("to_valid_ctl", 32'(ctl()), 32'b0000);
        @(negedge clk);
        mem_is_load = 0; mem_load_valid = 0;
        #1;
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk("to_cnt", stall_cycles, 32'd10);

        // Reset pulse mid-wait.
        @(negedge clk);
        mem_is_load = 1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 0;
        mem_reg_write = 1; mem_rd = 4; ex_rs2 = 4;
        #1;
        chk("rst_mid_ctl", 32'(ctl()), 32'b0000);
        chk("rst_mid_fb", 32'(forward_b), 32'd0);
        chk("rst_mid_cnt", stall_cycles, 32'd0);
        chk("rst_mid_timeout", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
        // RUN (not MEM_WAIT) must react to a load-use hazard.
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 2;
        id_rs1 = 2; id_uses_rs1 = 1;
        #1;
        chk("rst_state_run", 32'(ctl()), 32'b1010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
